// File: rtl/logit_pla_pkg.sv
// Shared constants, segment tables and pipeline payload types for the
// piecewise-linear logit (inverse sigmoid) unit.
package logit_pla_pkg;

  localparam int FRAC  = 8;
  localparam int GFRAC = 4;
  localparam int SAT_X = 1536;
  localparam int NSEG  = 8;
  localparam int KW    = 3;
  localparam int GW    = 12;
  localparam int PW    = 20;
  localparam int Y_LO  = 1;
  localparam int Y_HI  = 255;

  typedef enum logic [1:0] {
    SEG    = 2'd0,
    SAT_LO = 2'd1,
    SAT_HI = 2'd2
  } cls_e;

  // Knots sit on the forward sigmoid's breakpoints, so the two blocks round-trip.
  localparam logic [7:0] Y_TAB [NSEG] = '{
    8'd1, 8'd3, 8'd12, 8'd47, 8'd128, 8'd209, 8'd244, 8'd253
  };
  localparam logic signed [15:0] X_TAB [NSEG] = '{
    -16'sd1536, -16'sd1152, -16'sd768, -16'sd384,
    16'sd0, 16'sd384, 16'sd768, 16'sd1152
  };
  localparam logic [GW-1:0] G_TAB [NSEG] = '{
    12'd3072, 12'd683, 12'd176, 12'd76, 12'd76, 12'd176, 12'd683, 12'd3072
  };

  typedef struct packed {
    cls_e                 cls;
    logic [7:0]           y;
    logic [7:0]           yk;
    logic signed [15:0]   xk;
    logic [GW-1:0]        gk;
  } s1_t;

  typedef struct packed {
    cls_e               cls;
    logic signed [15:0] xk;
    logic [PW-1:0]      prod;
  } s2_t;

  function automatic logic signed [15:0] clamp_x(input logic signed [17:0] v);
    logic signed [17:0] lim;
    lim = 18'(SAT_X);
    if (v > lim)       return 16'(SAT_X);
    else if (v < -lim) return 16'(-SAT_X);
    else               return v[15:0];
  endfunction

endpackage

// File: rtl/logit_seg_lookup.sv
// Combinational classifier: picks the segment for a probability and returns
// its knot values and gain.
module logit_seg_lookup
  import logit_pla_pkg::*;
(
  input  logic [15:0]        y_i,
  output cls_e               cls_o,
  output logic [KW-1:0]      k_o,
  output logic [7:0]         yk_o,
  output logic signed [15:0] xk_o,
  output logic [GW-1:0]      gk_o,
  output logic               err_o
);

  always_comb begin
    k_o = '0;
    for (int i = 1; i < NSEG; i++)
      if (y_i >= {8'd0, Y_TAB[i]}) k_o = KW'(i);
  end

  always_comb begin
    if (y_i <= 16'(Y_LO))      cls_o = SAT_LO;
    else if (y_i >= 16'(Y_HI)) cls_o = SAT_HI;
    else                       cls_o = SEG;
  end

  assign yk_o  = Y_TAB[k_o];
  assign xk_o  = X_TAB[k_o];
  assign gk_o  = G_TAB[k_o];
  assign err_o = y_i > 16'(1 << FRAC);

endmodule

// File: rtl/logit8_pla.sv
// Q8.8 logit via 8 linear segments: classify -> multiply -> offset/clamp,
// globally stalled when the output is held, plus a range-error counter.
module logit8_pla
  import logit_pla_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      y_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [15:0]      x_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] range_err_cnt,
  input  logic             clear_err
);

  localparam int STAGES = 3;

  logic [STAGES:1]    vld_pipe_q;
  logic               stall, acc;
  s1_t                s1_d, s1_q;
  s2_t                s2_d, s2_q;
  logic signed [15:0] x_d, x_q;
  logic [CNT_W-1:0]   cnt_d, cnt_q;

  cls_e               lk_cls;
  logic [KW-1:0]      lk_k;
  logic [7:0]         lk_yk;
  logic signed [15:0] lk_xk;
  logic [GW-1:0]      lk_gk;
  logic               lk_err;

  logic [7:0]         d2;
  logic signed [17:0] sum3;

  assign stall    = vld_pipe_q[STAGES] && !out_ready;
  assign in_ready = !stall;
  assign acc      = in_valid && in_ready;

  logit_seg_lookup u_lookup (
    .y_i   (y_in),
    .cls_o (lk_cls),
    .k_o   (lk_k),
    .yk_o  (lk_yk),
    .xk_o  (lk_xk),
    .gk_o  (lk_gk),
    .err_o (lk_err)
  );

  always_comb begin
    s1_d     = '0;
    s1_d.cls = lk_cls;
    s1_d.y   = y_in[7:0];
    s1_d.yk  = lk_yk;
    s1_d.xk  = lk_xk;
    s1_d.gk  = lk_gk;
  end

  // Only meaningful for SEG, where y < 255 keeps the difference in 8 bits.
  assign d2 = s1_q.y - s1_q.yk;

  always_comb begin
    s2_d      = '0;
    s2_d.cls  = s1_q.cls;
    s2_d.xk   = s1_q.xk;
    s2_d.prod = PW'(d2) * PW'(s1_q.gk);
  end

  assign sum3 = {{2{s2_q.xk[15]}}, s2_q.xk} + {2'b00, s2_q.prod[PW-1:GFRAC]};

  always_comb begin
    x_d = '0;
    unique case (s2_q.cls)
      SAT_LO:  x_d = 16'(-SAT_X);
      SAT_HI:  x_d = 16'(SAT_X);
      default: x_d = clamp_x(sum3);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      x_q        <= '0;
    end else if (!stall) begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], acc};
      if (acc)           s1_q <= s1_d;
      if (vld_pipe_q[1]) s2_q <= s2_d;
      if (vld_pipe_q[2]) x_q  <= x_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clear_err)                          cnt_d = '0;
    else if (acc && lk_err && cnt_q != '1)  cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign x_out         = x_q;
  assign out_valid     = vld_pipe_q[STAGES];
  assign range_err_cnt = cnt_q;

endmodule

// File: tb/tb_logit8_pla.sv
// Scoreboard bench for logit8_pla: expected logits queued on accept,
// compared in order on every output transfer.
`timescale 1ns/1ps
module tb_logit8_pla;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] y_in = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        clear_err = 1'b0;
  logic        in_ready, out_valid;
  logic [15:0] x_out;
  logic [7:0]  range_err_cnt;

  always #5 clk = ~clk;

  logit8_pla #(.CNT_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .y_in          (y_in),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .x_out         (x_out),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .range_err_cnt (range_err_cnt),
    .clear_err     (clear_err)
  );

  int n_chk = 0, n_err = 0, cyc = 0, n_out = 0;
  int exp_q[$], acc_q[$], sweep_q[$];
  bit use_fixed = 0, chk_lat = 0, sweep_on = 0;
  int fixed_exp = 0;
  int mon_a;

  int YT[8] = '{1, 3, 12, 47, 128, 209, 244, 253};
  int XT[8] = '{-1536, -1152, -768, -384, 0, 384, 768, 1152};
  int GT[8] = '{3072, 683, 176, 76, 76, 176, 683, 3072};

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model(input int y);
    int k, x;
    if (y <= 1)   return -1536;
    if (y >= 255) return 1536;
    k = 0;
    for (int i = 1; i < 8; i++) if (y >= YT[i]) k = i;
    x = XT[k] + ((y - YT[k]) * GT[k]) / 16;
    if (x > 1536)  x = 1536;
    if (x < -1536) x = -1536;
    return x;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(use_fixed ? fixed_exp : model(int'(y_in)));
        acc_q.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) chk("spurious_out", exp_q.size(), 1);
        else begin
          chk("x_out", $signed(x_out), exp_q.pop_front());
          mon_a = acc_q.pop_front();
          if (chk_lat) chk("latency", cyc - mon_a, 3);
          if (sweep_on) sweep_q.push_back(int'($signed(x_out)));
        end
      end
    end
  end

  task automatic send(input int y);
    int n;
    y_in = 16'(y); in_valid = 1'b1; n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("send_timeout", n, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_x(input int y, input int e);
    fixed_exp = e;
    send(y);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin @(posedge clk); n++; end
    #1;
    chk("drain", exp_q.size(), 0);
  endtask

  int pt_y[5] = '{128, 47, 100, 210, 254};
  int pt_x[5] = '{0, -384, -133, 395, 1344};
  int st_y[4] = '{0, 1, 255, 256};
  int st_x[4] = '{-1536, -1536, 1536, 1536};
  logic [15:0] held;
  int n0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_x_out", $signed(x_out), 0);
    chk("rst_cnt", range_err_cnt, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);

    use_fixed = 1; chk_lat = 1;
    foreach (pt_y[i]) send_x(pt_y[i], pt_x[i]);
    drain();
    foreach (st_y[i]) send_x(st_y[i], st_x[i]);
    drain();
    chk("cnt_before_err", range_err_cnt, 0);
    send_x(300, 1536);
    chk("cnt_after_err", range_err_cnt, 1);
    drain();
    clear_err = 1'b1;
    @(posedge clk); #1;
    clear_err = 1'b0;
    chk("cnt_cleared", range_err_cnt, 0);

    use_fixed = 0; chk_lat = 0; n0 = n_out;
    fork
      begin
        for (int v = 10; v <= 250; v += 10) send(v);
      end
      begin
        repeat (8) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        held = x_out;
        chk("bp_in_ready", in_ready, 0);
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk("bp_in_ready", in_ready, 0);
          chk("bp_out_valid", out_valid, 1);
          chk("bp_hold", x_out, held);
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", n_out - n0, 25);

    chk_lat = 1; sweep_on = 1; sweep_q.delete();
    for (int y = 0; y <= 256; y++) send(y);
    drain();
    sweep_on = 0;
    chk("sweep_len", sweep_q.size(), 257);
    if (sweep_q.size() == 257) begin
      for (int i = 1; i <= 256; i++)
        chk("mono", int'(sweep_q[i] >= sweep_q[i-1]), 1);
      for (int k = 1; k < 8; k++)
        chk("knot", sweep_q[YT[k]], XT[k]);
    end

    send(300); send(40); send(200);
    chk("mid_cnt", range_err_cnt, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete(); acc_q.delete();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_cnt", range_err_cnt, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mid_rst_stale", out_valid, 0);
    end
    @(posedge clk); #1;

    chk_lat = 0;
    repeat (300) send(512);
    drain();
    chk("cnt_sat", range_err_cnt, 255);
    clear_err = 1'b1;
    send(512);
    clear_err = 1'b0;
    chk("cnt_clear_prio", range_err_cnt, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/logit8_pla.md
Name: logit8_pla

Overview:
- Inverse of the 8-slice PLA sigmoid: maps a Q8.8 probability y in [0,1] back to a Q8.8 pre-activation x ≈ ln(y/(1-y)).
- Uses 8 piecewise-linear segments whose knots are exactly the forward block's breakpoints (x = -6.0 … +6.0, step 1.5).
- Sits on the decode/calibration path after the sigmoid unit.
- Fully pipelined with a valid/ready handshake and backpressure. Keeps a saturating counter of out-of-range inputs.

Parameters:
- FRAC, 8, fractional bits of y_in and x_out (Q8.8).
- GFRAC, 4, fractional bits of the segment gains.
- SAT_X, 1536, output saturation magnitude (6.0 in Q8.8).
- CNT_W, 8, width of range_err_cnt.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- y_in  in  16  unsigned Q8.8 probability; legal range 0..256.
- in_valid  in  1  y_in valid.
- in_ready  out  1  block accepts y_in this cycle.
- x_out  out  16  signed Q8.8 logit.
- out_valid  out  1  x_out valid.
- out_ready  in  1  downstream accepts x_out.
- range_err_cnt  out  CNT_W  saturating count of accepted inputs with y_in > 256.
- clear_err  in  1  synchronous clear of range_err_cnt.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All stage valids = 0, out_valid = 0, x_out = 0, range_err_cnt = 0.
  - in_ready = 1 the cycle after reset is released.
  - Reset mid-stream drops every in-flight sample.
- Handshake:
  - Transfer-in when in_valid && in_ready; transfer-out when out_valid && out_ready.
  - stall = out_valid && !out_ready; in_ready = !stall (combinational).
  - While stall is high, every pipeline register holds, and x_out/out_valid are stable.
  - No sample is dropped or duplicated; order is preserved.
- Latency: 3 cycles from accept to out_valid when not stalled. Throughput is 1 sample per clock.
- Tables (index k = 0..7):
  - Y_k = 1, 3, 12, 47, 128, 209, 244, 253.
  - X_k = -1536 + 384k.
  - G_k (Q.4) = 3072, 683, 176, 76, 76, 176, 683, 3072.
- Stage 1 (on accept), registers y, class and k:
  - y <= 1 → class SAT_LO.
  - y >= 255 → class SAT_HI.
  - Otherwise class SEG, with k = largest index where y >= Y_k.
  - y > 256 also sets err_flag.
- Stage 2: d = y - Y_k, 8-bit unsigned, always >= 0. Registers prod = d * G_k, 20-bit unsigned.
- Stage 3 output:
  - SEG: x = X_k + (prod >> GFRAC), signed 16-bit, clamped to ±SAT_X.
  - SAT_LO: x = -SAT_X. SAT_HI: x = +SAT_X.
- range_err_cnt:
  - Increments by 1 when a Stage-1 accept has err_flag set; saturates at all-ones.
  - clear_err has priority over increment in the same cycle.
- Output is monotonic non-decreasing in y across all segment boundaries.

Decomposition:
- Package logit_pla_pkg holds FRAC, GFRAC, SAT_X, the Y_k/X_k/G_k tables as localparam arrays, and a 2-bit class enum {SEG, SAT_LO, SAT_HI}.
- Sub-module logit_seg_lookup is purely combinational. It takes y and returns class, k, Y_k, X_k, G_k and err_flag, and is instantiated once in Stage 1.
- Pipeline, stall logic and counter live in logit8_pla.

Test Plan:
- Point checks, out_ready=1: y_in = 128 → x_out 0; 47 → -384; 100 → -133; 210 → 395; 254 → 1344. Each appears exactly 3 cycles after accept.
- Saturation: y_in = 0 and 1 → -1536; 255 and 256 → +1536; 300 → +1536 with range_err_cnt 0→1. Then clear_err=1 → 0.
- Backpressure: stream y = 10, 20, …, 250, dropping out_ready for 5 cycles mid-stream. in_ready=0 while stalled, x_out is held, and all 25 outputs arrive in order with no loss.
- Monotonicity sweep: y = 0..256, one per cycle. Every output >= the previous output, and output at y=Y_k equals X_k for k=1..7.
- Reset mid-operation: assert rst_n=0 for 1 cycle with 3 samples in flight → out_valid=0 on the next cycle, no stale outputs afterwards, range_err_cnt=0.
- Counter saturation: feed 300 invalid samples (y=512) → range_err_cnt stops at 255. A simultaneous clear_err and error sample → 0.
